// File: rtl/dac_spi_tx.sv
// ============================================================================
// Module   : dac_spi_tx
// Brief    : SPI mode-0 transmitter of {CMD, code} frames to the loop-control
//            DAC, with LDAC strobe, done/abort pulses and last-loaded code.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dac_spi_tx #(
    parameter int          DATA_W  = 12,
    parameter logic [3:0]  CMD     = 4'h3,
    parameter int          CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              swiptAlive,
    input  logic [DATA_W-1:0] dac_data,
    input  logic              dac_valid,
    output logic              dac_ready,
    output logic              dac_sclk,
    output logic              dac_sdi,
    output logic              dac_csn,
    output logic              dac_ldac_n,
    output logic              done,
    output logic              aborted,
    output logic [DATA_W-1:0] last_code
);

    localparam int c_FRAME_W = DATA_W + 4;
    localparam int c_BIT_W   = $clog2(c_FRAME_W);
    localparam int c_PH_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_PH_W-1:0]  c_PH_LAST = c_PH_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_TOP = c_BIT_W'(c_FRAME_W - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_LDAC  = 3'd4;

    logic [2:0]           state_q,  state_d;
    logic [c_PH_W-1:0]    phase_q,  phase_d;
    logic [c_BIT_W-1:0]   bit_q,    bit_d;
    logic [c_FRAME_W-1:0] frame_q,  frame_d;
    logic                 sclk_q,   sclk_d;
    logic                 sdi_q,    sdi_d;
    logic                 csn_q,    csn_d;
    logic                 ldac_n_q, ldac_n_d;
    logic                 ready_q,  ready_d;
    logic                 done_q,   done_d;
    logic                 abort_q,  abort_d;
    logic [DATA_W-1:0]    last_q,   last_d;

    logic                 w_accept;
    logic                 w_abort;
    logic                 w_phase_end;
    logic                 w_bit_last;
    logic [c_BIT_W-1:0]   w_next_bit;
    logic [c_FRAME_W-1:0] w_frame_in;

    assign w_accept    = (state_q == S_IDLE) && dac_valid && ready_q && swiptAlive;
    assign w_abort     = (state_q != S_IDLE) && !swiptAlive;
    assign w_phase_end = (phase_q == c_PH_LAST);
    assign w_bit_last  = (bit_q == '0);
    assign w_next_bit  = bit_q - 1'b1;
    assign w_frame_in  = {CMD, dac_data};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            phase_q  <= '0;
            bit_q    <= '0;
            frame_q  <= '0;
            sclk_q   <= 1'b0;
            sdi_q    <= 1'b0;
            csn_q    <= 1'b1;
            ldac_n_q <= 1'b1;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            last_q   <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            frame_q  <= frame_d;
            sclk_q   <= sclk_d;
            sdi_q    <= sdi_d;
            csn_q    <= csn_d;
            ldac_n_q <= ldac_n_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
            last_q   <= last_d;
        end
    end

    // Next state and counters; the SCLK level tells which half-bit is running.
    always_comb begin
        state_d = state_q;
        phase_d = w_phase_end ? '0 : phase_q + 1'b1;
        bit_d   = bit_q;
        frame_d = frame_q;
        case (state_q)
            S_IDLE: begin
                phase_d = '0;
                if (w_accept) begin
                    state_d = S_SETUP;
                    bit_d   = c_BIT_TOP;
                    frame_d = w_frame_in;
                end
            end
            S_SETUP: if (w_phase_end) state_d = S_SHIFT;
            S_SHIFT: begin
                if (w_phase_end && sclk_q) begin
                    if (w_bit_last) state_d = S_HOLD;
                    else            bit_d   = w_next_bit;
                end
            end
            S_HOLD:  if (w_phase_end) state_d = S_LDAC;
            S_LDAC:  if (w_phase_end) state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase
        if (w_abort) begin
            state_d = S_IDLE;
            phase_d = '0;
            bit_d   = '0;
        end
    end

    always_comb begin
        sclk_d   = sclk_q;
        sdi_d    = sdi_q;
        csn_d    = csn_q;
        ldac_n_d = ldac_n_q;
        ready_d  = 1'b0;
        done_d   = 1'b0;
        abort_d  = 1'b0;
        last_d   = last_q;
        case (state_q)
            S_IDLE: begin
                sclk_d   = 1'b0;
                csn_d    = 1'b1;
                ldac_n_d = 1'b1;
                ready_d  = swiptAlive;
                if (w_accept) begin
                    ready_d = 1'b0;
                    csn_d   = 1'b0;
                    sdi_d   = w_frame_in[c_FRAME_W-1];
                end
            end
            S_SHIFT: begin
                if (w_phase_end) begin
                    sclk_d = !sclk_q;
                    // Data moves only on the falling edge so it is stable while SCLK is high.
                    if (sclk_q && !w_bit_last) sdi_d = frame_q[w_next_bit];
                end
            end
            S_HOLD: begin
                if (w_phase_end) begin
                    csn_d    = 1'b1;
                    ldac_n_d = 1'b0;
                    sdi_d    = 1'b0;
                end
            end
            S_LDAC: begin
                if (w_phase_end) begin
                    ldac_n_d = 1'b1;
                    done_d   = 1'b1;
                    last_d   = frame_q[DATA_W-1:0];
                    ready_d  = swiptAlive;
                end
            end
            default: ;
        endcase
        if (w_abort) begin
            sclk_d   = 1'b0;
            sdi_d    = 1'b0;
            csn_d    = 1'b1;
            ldac_n_d = 1'b1;
            ready_d  = 1'b0;
            done_d   = 1'b0;
            abort_d  = 1'b1;
            last_d   = last_q;
        end
    end

    assign dac_ready  = ready_q;
    assign dac_sclk   = sclk_q;
    assign dac_sdi    = sdi_q;
    assign dac_csn    = csn_q;
    assign dac_ldac_n = ldac_n_q;
    assign done       = done_q;
    assign aborted    = abort_q;
    assign last_code  = last_q;

endmodule

`default_nettype wire
